// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default watchdog limit for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side handshake bundle around mem_arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_err;
  logic              busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_valid,
    output if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_wr, mem_addr, mem_wdata, mem_err, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_wr, mem_addr, mem_wdata, mem_err, busy
  );
endinterface

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: BUSY-cycle watchdog, pulses expired on the TIMEOUT-th busy cycle
module mem_arb_timeout #(parameter int TIMEOUT = 64) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // clear when an access is granted, count every busy cycle
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= start ? '0 : run ? cnt + CW'(1) : cnt;
  assign expired = run && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (DM over IF) sharing of one multi-cycle memory; watchdog under MEM_ARB_TIMEOUT_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);
  state_t            state, state_nx;
  owner_t            owner;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rd, dm_rd, rd_val;
  logic              req_any, grant, fin, expired, err_q;
  assign req_any = bus.dm_req | bus.if_req;
  assign grant   = (state == IDLE) && req_any;
  assign fin     = (state == BUSY) && (bus.mem_valid || expired);
  assign rd_val  = bus.mem_valid ? bus.mem_rdata : '1;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: grant from IDLE, finish BUSY on response or watchdog, DONE always returns
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (req_any ? BUSY : IDLE) : (state == BUSY) ? (fin ? DONE : BUSY) : IDLE;
  end
  // command capture at grant and per-owner read data capture at completion
  always_ff @(posedge clk)
    if (!rst_n) begin
      owner   <= OWN_IF;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      if_rd   <= '0;
      dm_rd   <= '0;
    end else begin
      if (grant) begin
        owner   <= bus.dm_req ? OWN_DM : OWN_IF;
        wr_q    <= bus.dm_req & bus.dm_wr;
        addr_q  <= bus.dm_req ? bus.dm_addr : bus.if_addr;
        wdata_q <= bus.dm_req ? bus.dm_wdata : wdata_q;
      end
      if (fin && owner == OWN_IF) if_rd <= rd_val;
      if (fin && owner == OWN_DM && !wr_q) dm_rd <= rd_val;
    end
`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (grant),
    .run     (state == BUSY),
    .expired (expired)
  );
  // sticky error: a watchdog abort that the memory did not beat in the same cycle
  always_ff @(posedge clk)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | ((state == BUSY) && expired && !bus.mem_valid);
`else
  assign expired = 1'b0;
  assign err_q   = 1'b0;
`endif
  assign bus.mem_en    = state == BUSY;
  assign bus.mem_wr    = wr_q & (state == BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = (state == DONE) && (owner == OWN_IF);
  assign bus.dm_done   = (state == DONE) && (owner == OWN_DM);
  assign bus.if_rdata  = if_rd;
  assign bus.dm_rdata  = dm_rd;
  assign bus.mem_err   = err_q;
  assign bus.busy      = state != IDLE;
endmodule
